// File: rtl/tuple_rr_arb.sv
// Two-input round-robin merge of tuple streams into one registered output stage,
// with per-stream end tracking and a RUN/DRAIN/DONE completion handshake.
module tuple_rr_arb #(
   parameter int INPUT_SIZE = 64
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic [1:0]                 in_valid,
   output logic [1:0]                 in_ready,
   input  logic [1:0][INPUT_SIZE-1:0] in_data,
   input  logic [1:0][31:0]           in_tag,
   input  logic [1:0]                 in_last_processed,
   input  logic [1:0][63:0]           in_serialnum,
   input  logic [1:0]                 in_was_joined,
   input  logic                       out_ready,
   output logic                       out_valid,
   output logic [INPUT_SIZE-1:0]      out_data,
   output logic [31:0]                out_tag,
   output logic                       out_last_processed,
   output logic [63:0]                out_serialnum,
   output logic                       out_was_joined,
   input  logic                       restart,
   output logic                       all_done,
   output logic [31:0]                out_count
);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [1:0]              r_done;
   logic                    r_prio;
   logic [31:0]             r_count;
   logic                    r_out_valid;
   logic [INPUT_SIZE-1:0]   r_out_data;
   logic [31:0]             r_out_tag;
   logic                    r_out_last;
   logic [63:0]             r_out_serialnum;
   logic                    r_out_was_joined;

   logic                    w_can_load;
   logic [1:0]              w_eligible;
   logic [1:0]              w_grant;
   logic                    w_in_xfer;
   logic                    w_out_xfer;
   logic                    w_sel;
   logic                    w_restart;

   assign w_can_load = !r_out_valid || out_ready;
   assign w_eligible = in_valid & ~r_done & {2{r_state == RUN}};

   always_comb begin
      // NOTE: assign a default before any condition so no path leaves w_grant unassigned (no latch).
      w_grant = w_eligible;
      if (w_eligible == 2'b11) begin
         w_grant = r_prio ? 2'b10 : 2'b01;
      end
   end

   assign in_ready   = w_grant & {2{w_can_load}};
   assign w_in_xfer  = |(in_ready & in_valid);
   assign w_sel      = in_ready[1];
   assign w_out_xfer = r_out_valid && out_ready;
   assign w_restart  = (r_state == DONE) && restart;

   // State register
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!resetn) begin
         r_state <= RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; DRAIN waits for the output register to empty
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (r_done == 2'b11) w_state_nxt = DRAIN;
         DRAIN:   if (!r_out_valid || out_ready) w_state_nxt = DONE;
         DONE:    if (restart) w_state_nxt = RUN;
         default: w_state_nxt = RUN;
      endcase
   end

   // State-decoded outputs
   always_comb begin
      all_done = (r_state == DONE);
   end

   // Stream bookkeeping: done flags, round-robin pointer, output handshake count
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_done  <= 2'b00;
         r_prio  <= 1'b0;
         r_count <= 32'd0;
      end else if (w_restart) begin
         r_done  <= 2'b00;
         r_prio  <= 1'b0;
         r_count <= 32'd0;
      end else begin
         if (w_in_xfer) begin
            r_prio <= ~w_sel;
            if (in_last_processed[w_sel]) begin
               r_done[w_sel] <= 1'b1;
            end
         end
         if (w_out_xfer) begin
            r_count <= r_count + 32'd1;
         end
      end
   end

   // Output register; last is flagged only on the tuple that closes the second stream
   always_ff @(posedge clk or negedge resetn) begin
      // NOTE: payload flops are reset too, so nothing from a prior run is visible after reset.
      if (!resetn) begin
         r_out_valid      <= 1'b0;
         r_out_data       <= '0;
         r_out_tag        <= 32'd0;
         r_out_last       <= 1'b0;
         r_out_serialnum  <= 64'd0;
         r_out_was_joined <= 1'b0;
      end else if (w_in_xfer) begin
         r_out_valid      <= 1'b1;
         r_out_data       <= in_data[w_sel];
         r_out_tag        <= in_tag[w_sel];
         r_out_last       <= in_last_processed[w_sel] && r_done[~w_sel];
         r_out_serialnum  <= in_serialnum[w_sel];
         r_out_was_joined <= in_was_joined[w_sel];
      end else if (w_out_xfer) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid          = r_out_valid;
   assign out_data           = r_out_data;
   assign out_tag            = r_out_tag;
   assign out_last_processed = r_out_last;
   assign out_serialnum      = r_out_serialnum;
   assign out_was_joined     = r_out_was_joined;
   assign out_count          = r_count;

endmodule

// File: tb/tb_tuple_rr_arb.sv
// Bench for tuple_rr_arb: directed scenarios plus random traffic, compared each
// cycle against a queue-based reference of the merged stream.
module tb_tuple_rr_arb;

   localparam int W = 64;

   typedef struct {
      logic [W-1:0] data;
      logic [31:0]  tag;
      logic         last;
      logic [63:0]  sn;
      logic         joined;
   } tup_t;

   logic              clk = 1'b0;
   logic              resetn;
   logic [1:0]        in_valid;
   logic [1:0]        in_ready;
   logic [1:0][W-1:0] in_data;
   logic [1:0][31:0]  in_tag;
   logic [1:0]        in_last_processed;
   logic [1:0][63:0]  in_serialnum;
   logic [1:0]        in_was_joined;
   logic              out_ready;
   logic              out_valid;
   logic [W-1:0]      out_data;
   logic [31:0]       out_tag;
   logic              out_last_processed;
   logic [63:0]       out_serialnum;
   logic              out_was_joined;
   logic              restart;
   logic              all_done;
   logic [31:0]       out_count;

   always #5 clk = ~clk;

   tuple_rr_arb #(.INPUT_SIZE(W)) dut (
      .clk                (clk),
      .resetn             (resetn),
      .in_valid           (in_valid),
      .in_ready           (in_ready),
      .in_data            (in_data),
      .in_tag             (in_tag),
      .in_last_processed  (in_last_processed),
      .in_serialnum       (in_serialnum),
      .in_was_joined      (in_was_joined),
      .out_ready          (out_ready),
      .out_valid          (out_valid),
      .out_data           (out_data),
      .out_tag            (out_tag),
      .out_last_processed (out_last_processed),
      .out_serialnum      (out_serialnum),
      .out_was_joined     (out_was_joined),
      .restart            (restart),
      .all_done           (all_done),
      .out_count          (out_count)
   );

   int          checks = 0;
   int          errors = 0;

   // Reference: pending outputs as a queue, stream-done flags, turn pointer, phase 0/1/2
   tup_t        mq[$];
   logic [1:0]  m_done;
   int          m_prio;
   int unsigned m_count;
   int          m_phase;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_done  = 2'b00;
      m_prio  = 0;
      m_count = 0;
      m_phase = 0;
   endtask

   task automatic rand_tuples(input logic [1:0] valid, input logic [1:0] last);
      for (int i = 0; i < 2; i++) begin
         in_data[i]       = {$urandom, $urandom};
         in_tag[i]        = $urandom;
         in_serialnum[i]  = {$urandom, $urandom};
         in_was_joined[i] = 1'($urandom_range(0, 1));
      end
      in_valid          = valid;
      in_last_processed = last;
   endtask

   // One clock cycle: compare at the falling edge, advance the reference, return #1 after the rising edge
   task automatic step(output logic [1:0] rdy);
      logic [1:0] elig;
      logic [1:0] exp_rdy;
      logic       can_load;
      int         nxt;
      int         w;
      tup_t       t;
      @(negedge clk);
      can_load = (mq.size() == 0) || out_ready;
      for (int i = 0; i < 2; i++) begin
         elig[i] = in_valid[i] && !m_done[i] && (m_phase == 0);
      end
      if (elig == 2'b11) exp_rdy = (m_prio == 1) ? 2'b10 : 2'b01;
      else               exp_rdy = elig;
      if (!can_load) exp_rdy = 2'b00;
      chk("in_ready", {62'd0, in_ready}, {62'd0, exp_rdy});
      chk("out_valid", {63'd0, out_valid}, {63'd0, mq.size() != 0});
      if (mq.size() != 0) begin
         chk("out_data", out_data, mq[0].data);
         chk("out_tag", {32'd0, out_tag}, {32'd0, mq[0].tag});
         chk("out_last", {63'd0, out_last_processed}, {63'd0, mq[0].last});
         chk("out_serialnum", out_serialnum, mq[0].sn);
         chk("out_was_joined", {63'd0, out_was_joined}, {63'd0, mq[0].joined});
      end
      chk("all_done", {63'd0, all_done}, {63'd0, m_phase == 2});
      chk("out_count", {32'd0, out_count}, {32'd0, m_count});
      rdy = in_ready;

      nxt = m_phase;
      case (m_phase)
         0:       if (m_done == 2'b11) nxt = 1;
         1:       if (mq.size() == 0 || out_ready) nxt = 2;
         2:       if (restart) nxt = 0;
         default: nxt = 0;
      endcase
      if (mq.size() != 0 && out_ready) begin
         void'(mq.pop_front());
         m_count++;
      end
      if (exp_rdy != 2'b00) begin
         w        = exp_rdy[1] ? 1 : 0;
         t.data   = in_data[w];
         t.tag    = in_tag[w];
         t.sn     = in_serialnum[w];
         t.joined = in_was_joined[w];
         t.last   = in_last_processed[w] && m_done[1-w];
         mq.push_back(t);
         if (in_last_processed[w]) m_done[w] = 1'b1;
         m_prio = 1 - w;
      end
      if (m_phase == 2 && restart) begin
         m_done  = 2'b00;
         m_count = 0;
         m_prio  = 0;
      end
      m_phase = nxt;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [1:0]   rdy;
      logic [W-1:0] held;
      logic [W-1:0] next_data;

      resetn            = 1'b0;
      restart           = 1'b0;
      out_ready         = 1'b1;
      in_valid          = 2'b00;
      in_data           = '0;
      in_tag            = '0;
      in_last_processed = 2'b00;
      in_serialnum      = '0;
      in_was_joined     = 2'b00;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
      chk("rst_out_count", {32'd0, out_count}, 64'd0);
      chk("rst_all_done", {63'd0, all_done}, 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_tag", {32'd0, out_tag}, 64'd0);
      chk("rst_out_sn", out_serialnum, 64'd0);
      chk("rst_out_joined", {63'd0, out_was_joined}, 64'd0);
      chk("rst_out_last", {63'd0, out_last_processed}, 64'd0);
      resetn = 1'b1;

      // Both inputs always valid: strict alternation starting at input 0
      for (int i = 0; i < 6; i++) begin
         rand_tuples(2'b11, 2'b00);
         step(rdy);
         chk("alt_grant", {62'd0, rdy}, (i % 2 == 0) ? 64'd1 : 64'd2);
      end
      rand_tuples(2'b00, 2'b00);
      step(rdy);
      chk("count_after_6", {32'd0, out_count}, 64'd6);

      // Only input 1 valid: serial numbers stream out back-to-back
      for (int i = 0; i < 3; i++) begin
         rand_tuples(2'b10, 2'b00);
         in_serialnum[1] = 64'(5 + i);
         step(rdy);
         chk("b2b_valid", {63'd0, out_valid}, 64'd1);
         chk("b2b_sn", out_serialnum, 64'(5 + i));
      end
      rand_tuples(2'b11, 2'b00);
      step(rdy);
      chk("prio_after_in1", {62'd0, rdy}, 64'd1);

      // Backpressure: output held, no grants; release gives a load with no bubble
      held      = out_data;
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         rand_tuples(2'b11, 2'b00);
         step(rdy);
         chk("stall_ready", {62'd0, rdy}, 64'd0);
         chk("stall_data", out_data, held);
      end
      out_ready = 1'b1;
      rand_tuples(2'b11, 2'b00);
      next_data = in_data[1];
      step(rdy);
      chk("release_grant", {62'd0, rdy}, 64'd2);
      chk("release_valid", {63'd0, out_valid}, 64'd1);
      chk("release_data", out_data, next_data);

      // Random traffic with random backpressure; restart must be ignored in RUN
      for (int i = 0; i < 300; i++) begin
         rand_tuples(2'($urandom_range(0, 3)), 2'b00);
         out_ready = 1'($urandom_range(0, 1));
         restart   = 1'($urandom_range(0, 1));
         step(rdy);
      end
      restart   = 1'b0;
      out_ready = 1'b1;

      // Input 0 finishes first, then input 1 sends two tuples ending its stream
      rand_tuples(2'b01, 2'b01);
      step(rdy);
      chk("last0_not_final", {63'd0, out_last_processed}, 64'd0);
      rand_tuples(2'b10, 2'b00);
      step(rdy);
      chk("mid1_not_final", {63'd0, out_last_processed}, 64'd0);
      rand_tuples(2'b10, 2'b10);
      step(rdy);
      chk("final_last", {63'd0, out_last_processed}, 64'd1);
      rand_tuples(2'b11, 2'b00);
      step(rdy);
      chk("drain_no_grant", {62'd0, rdy}, 64'd0);
      chk("drain_not_done", {63'd0, all_done}, 64'd0);
      restart = 1'b1;
      step(rdy);
      restart = 1'b0;
      chk("done_asserted", {63'd0, all_done}, 64'd1);
      step(rdy);
      chk("done_no_grant", {62'd0, rdy}, 64'd0);
      chk("done_held", {63'd0, all_done}, 64'd1);

      // Restart from DONE: counters clear and input 0 wins first
      restart = 1'b1;
      step(rdy);
      restart = 1'b0;
      chk("restart_all_done", {63'd0, all_done}, 64'd0);
      chk("restart_count", {32'd0, out_count}, 64'd0);
      rand_tuples(2'b11, 2'b00);
      step(rdy);
      chk("restart_grant0", {62'd0, rdy}, 64'd1);

      // Simultaneous last on both inputs: one per cycle, second carries the final flag
      rand_tuples(2'b11, 2'b11);
      step(rdy);
      chk("both_last_first", {62'd0, rdy}, 64'd2);
      chk("both_last_first_flag", {63'd0, out_last_processed}, 64'd0);
      rand_tuples(2'b11, 2'b11);
      step(rdy);
      chk("both_last_second", {62'd0, rdy}, 64'd1);
      chk("both_last_second_flag", {63'd0, out_last_processed}, 64'd1);
      rand_tuples(2'b00, 2'b00);
      repeat (3) step(rdy);
      chk("both_last_done", {63'd0, all_done}, 64'd1);
      restart = 1'b1;
      step(rdy);
      restart = 1'b0;

      // Asynchronous reset while the output register holds a tuple
      rand_tuples(2'b01, 2'b00);
      step(rdy);
      chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
      resetn = 1'b0;
      #1;
      chk("async_rst_valid", {63'd0, out_valid}, 64'd0);
      chk("async_rst_count", {32'd0, out_count}, 64'd0);
      chk("async_rst_data", out_data, 64'd0);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
      for (int i = 0; i < 20; i++) begin
         rand_tuples(2'($urandom_range(0, 3)), 2'b00);
         out_ready = 1'($urandom_range(0, 1));
         step(rdy);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
